// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared widths, depth and the RAM-port grant encoding for the single-port RAM FIFO controller.
package spram_fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 2;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_WRITE = 2'd1,
        GNT_READ  = 2'd2
    } grant_e;

    function automatic int cnt_width(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// Push stream, pop stream and RAM pins of the FIFO controller, bundled for port lists.
interface spram_fifo_ctrl_if
    import spram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_push_valid;
    logic [DATA_W-1:0] in_push_data;
    logic              out_push_ready;
    logic              out_pop_valid;
    logic [DATA_W-1:0] out_pop_data;
    logic              in_pop_ready;
    logic              out_ram_enable;
    logic              out_ram_write;
    logic [ADDR_W-1:0] out_ram_address;
    logic [DATA_W-1:0] out_ram_data;
    logic [DATA_W-1:0] in_ram_data;

    modport slave (
        input  in_push_valid, in_push_data, in_pop_ready, in_ram_data,
        output out_push_ready, out_pop_valid, out_pop_data,
               out_ram_enable, out_ram_write, out_ram_address, out_ram_data
    );

    modport master (
        output in_push_valid, in_push_data, in_pop_ready, in_ram_data,
        input  out_push_ready, out_pop_valid, out_pop_data,
               out_ram_enable, out_ram_write, out_ram_address, out_ram_data
    );
endinterface

// File: rtl/spram_fifo_ctrl_obuf.sv
// Two-entry output prefetch buffer; captures RAM read data at the tail and presents the head.
module spram_fifo_obuf
    import spram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              in_clock,
    input  logic              in_reset_n,
    input  logic              in_capture,
    input  logic [DATA_W-1:0] in_capture_data,
    input  logic              in_pop,
    output logic [DATA_W-1:0] out_head_data,
    output logic [1:0]        out_count
);
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        // NOTE: every signal written here gets a default first; a branch that skipped one would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({in_capture, in_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_capture_data;
                else                 tail_d = in_capture_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = in_capture_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_capture_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the data entries are reset as well so the head reads zero out of reset; bulk RAM arrays are never reset.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_head_data = head_q;
    assign out_count     = count_q;
endmodule

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller in front of a 1-port RAM: arbitrates one read or write per cycle and
// hides the 1-cycle read latency with a 2-entry prefetch buffer.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              in_clock,
    input  logic              in_reset_n,
    spram_fifo_ctrl_if.slave  bus,
    output logic [ADDR_W+1:0] out_count,
    output logic              out_full,
    output logic              out_empty
);
    localparam int              CNT_W = cnt_width(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

    localparam logic PRIO_WRITE = 1'b0;
    localparam logic PRIO_READ  = 1'b1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_count_q, ram_count_d;
    logic              rd_pend_q, rd_pend_d;
    logic              prio_q, prio_d;

    logic       read_req;
    logic       write_req;
    logic       pop;
    logic [1:0] obuf_count;
    grant_e     grant;

    assign read_req  = (ram_count_q != '0) &&
                       (({1'b0, obuf_count} + {2'b00, rd_pend_q}) < 3'd2);
    assign write_req = bus.in_push_valid && (ram_count_q < DEPTH);
    assign pop       = bus.in_pop_ready && (obuf_count != 2'd0);

    // Contested cycles go to the side that lost last time, so both streams get half the RAM.
    always_comb begin
        grant  = GNT_NONE;
        prio_d = prio_q;
        if (read_req && write_req) begin
            if (prio_q == PRIO_WRITE) begin
                grant  = GNT_READ;
                prio_d = PRIO_READ;
            end else begin
                grant  = GNT_WRITE;
                prio_d = PRIO_WRITE;
            end
        end else if (write_req) begin
            grant = GNT_WRITE;
        end else if (read_req) begin
            grant = GNT_READ;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        rd_pend_d   = 1'b0;
        case (grant)
            GNT_WRITE: begin
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                ram_count_d = ram_count_q + CNT_W'(1);
            end
            GNT_READ: begin
                rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                ram_count_d = ram_count_q - CNT_W'(1);
                rd_pend_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            rd_pend_q   <= 1'b0;
            prio_q      <= PRIO_WRITE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            rd_pend_q   <= rd_pend_d;
            prio_q      <= prio_d;
        end
    end

    spram_fifo_obuf #(
        .DATA_W(DATA_W)
    ) u_obuf (
        .in_clock        (in_clock),
        .in_reset_n      (in_reset_n),
        .in_capture      (rd_pend_q),
        .in_capture_data (bus.in_ram_data),
        .in_pop          (pop),
        .out_head_data   (bus.out_pop_data),
        .out_count       (obuf_count)
    );

    assign bus.out_push_ready  = (ram_count_q < DEPTH) && !(read_req && (prio_q == PRIO_WRITE));
    assign bus.out_pop_valid   = (obuf_count != 2'd0);
    assign bus.out_ram_enable  = (grant != GNT_NONE);
    assign bus.out_ram_write   = (grant == GNT_WRITE);
    assign bus.out_ram_address = (grant == GNT_READ) ? rd_ptr_q : wr_ptr_q;
    assign bus.out_ram_data    = bus.in_push_data;

    assign out_count = ram_count_q + CNT_W'(obuf_count) + CNT_W'(rd_pend_q);
    assign out_full  = (ram_count_q == DEPTH);
    assign out_empty = (out_count == '0);
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl with a behavioural 1024x16 registered-read RAM beside it.
module tb_spram_fifo_ctrl;
    import spram_fifo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [11:0] count;
    logic        full;
    logic        empty;
    int          n_tests;
    int          n_fail;

    spram_fifo_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bus ();

    spram_fifo_ctrl #(.DATA_W(16), .ADDR_W(10)) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus),
        .out_count  (count),
        .out_full   (full),
        .out_empty  (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] mem [1024];
    always @(posedge clk) begin
        if (bus.out_ram_enable) begin
            if (bus.out_ram_write) mem[bus.out_ram_address] <= bus.out_ram_data;
            else                   bus.in_ram_data <= mem[bus.out_ram_address];
        end
    end

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        pr;
        logic        e_pready;
        logic        e_pvalid;
        logic [15:0] e_pdata;
        logic        e_en;
        logic        e_wr;
        logic [9:0]  e_addr;
        logic [11:0] e_count;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [15:0] pd, input logic pr);
        bus.in_push_valid = pv;
        bus.in_push_data  = pd;
        bus.in_pop_ready  = pr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pop_valid"},  32'(bus.out_pop_valid), 32'd0);
        check({tag, "_pop_data"},   32'(bus.out_pop_data), 32'd0);
        check({tag, "_push_ready"}, 32'(bus.out_push_ready), 32'd1);
        check({tag, "_ram_en"},     32'(bus.out_ram_enable), 32'd0);
        check({tag, "_ram_wr"},     32'(bus.out_ram_write), 32'd0);
        check({tag, "_ram_addr"},   32'(bus.out_ram_address), 32'd0);
        check({tag, "_count"},      32'(count), 32'd0);
        check({tag, "_full"},       32'(full), 32'd0);
        check({tag, "_empty"},      32'(empty), 32'd1);
    endtask

    initial begin
        int accepted, popped, mism, alt_err, push_idx, pop_idx, cyc;
        logic prev_wr;

        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 10'd0, 12'd0};
        vecs[1] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 10'd0, 12'd1};
        vecs[2] = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 10'd1, 12'd1};
        vecs[3] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 10'd2, 12'd2};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 10'd1, 12'd3};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 10'd3, 12'd3};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0, 10'd2, 12'd2};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd3, 12'd1};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 10'd3, 12'd1};
        vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 10'd3, 12'd0};

        rst_n = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: three pushes with contention, then drain
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].pd, vecs[i].pr);
            #1;
            check($sformatf("v%0d_push_ready", i), 32'(bus.out_push_ready), 32'(vecs[i].e_pready));
            check($sformatf("v%0d_pop_valid", i),  32'(bus.out_pop_valid),  32'(vecs[i].e_pvalid));
            if (vecs[i].e_pvalid)
                check($sformatf("v%0d_pop_data", i), 32'(bus.out_pop_data), 32'(vecs[i].e_pdata));
            check($sformatf("v%0d_ram_en", i),   32'(bus.out_ram_enable),  32'(vecs[i].e_en));
            check($sformatf("v%0d_ram_wr", i),   32'(bus.out_ram_write),   32'(vecs[i].e_wr));
            check($sformatf("v%0d_ram_addr", i), 32'(bus.out_ram_address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_count", i),    32'(count),               32'(vecs[i].e_count));
            check($sformatf("v%0d_empty", i),    32'(empty),               32'(vecs[i].e_count == 12'd0));
        end

        // Single push latency: valid in the third cycle after the accepting edge
        do_reset();
        @(negedge clk);
        drive(1'b1, 16'hA5A5, 1'b1);
        #1 check("lat_c0_write", 32'({bus.out_push_ready, bus.out_ram_enable, bus.out_ram_write}), 32'b111);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b1);
        #1 check("lat_c1_read", 32'({bus.out_pop_valid, bus.out_ram_enable, bus.out_ram_write}), 32'b010);
        check("lat_c1_count", 32'(count), 32'd1);
        @(negedge clk);
        #1 check("lat_c2_valid", 32'(bus.out_pop_valid), 32'd0);
        @(negedge clk);
        #1 check("lat_c3_valid", 32'(bus.out_pop_valid), 32'd1);
        check("lat_c3_data", 32'(bus.out_pop_data), 32'hA5A5);
        check("lat_c3_count", 32'(count), 32'd1);
        @(negedge clk);
        #1 check("lat_c4_count", 32'(count), 32'd0);
        check("lat_c4_valid", 32'(bus.out_pop_valid), 32'd0);

        // Fill to capacity with the consumer stalled, then drain in order
        do_reset();
        accepted = 0;
        for (int c = 0; c < 2200; c++) begin
            @(negedge clk);
            drive(1'b1, 16'(accepted), 1'b0);
            #1;
            if (bus.out_push_ready) accepted++;
        end
        check("fill_accepted", 32'(accepted), 32'd1026);
        check("fill_full", 32'(full), 32'd1);
        check("fill_push_ready", 32'(bus.out_push_ready), 32'd0);
        check("fill_count", 32'(count), 32'd1026);
        popped = 0;
        mism   = 0;
        for (int c = 0; c < 3000 && popped < 1026; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 1'b1);
            #1;
            if (bus.out_pop_valid) begin
                if (bus.out_pop_data !== 16'(popped)) mism++;
                popped++;
            end
        end
        check("drain_words", 32'(popped), 32'd1026);
        check("drain_order_errors", 32'(mism), 32'd0);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0);
        #1 check("drain_empty", 32'(empty), 32'd1);

        // Both streams saturated: accesses alternate write/read every cycle
        do_reset();
        push_idx = 0;
        pop_idx  = 0;
        mism     = 0;
        alt_err  = 0;
        prev_wr  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            drive(1'b1, 16'(push_idx), 1'b1);
            #1;
            if (bus.out_push_ready) push_idx++;
            if (bus.out_pop_valid) begin
                if (bus.out_pop_data !== 16'(pop_idx)) mism++;
                pop_idx++;
            end
            if (c >= 4 && (!bus.out_ram_enable || bus.out_ram_write == prev_wr)) alt_err++;
            prev_wr = bus.out_ram_write;
        end
        check("alt_violations", 32'(alt_err), 32'd0);
        check("alt_order_errors", 32'(mism), 32'd0);
        check("alt_half_rate", 32'(pop_idx > 90 && pop_idx <= 100), 32'd1);

        // Random valid/ready over 3000 words: two pointer wraps
        do_reset();
        push_idx = 0;
        pop_idx  = 0;
        mism     = 0;
        cyc      = 0;
        while (pop_idx < 3000 && cyc < 40000) begin
            @(negedge clk);
            drive(push_idx < 3000 && $urandom_range(0, 3) != 0, 16'(push_idx),
                  $urandom_range(0, 2) != 0);
            #1;
            if (bus.in_push_valid && bus.out_push_ready) push_idx++;
            if (bus.in_pop_ready && bus.out_pop_valid) begin
                if (bus.out_pop_data !== 16'(pop_idx)) mism++;
                pop_idx++;
            end
            cyc++;
        end
        check("rand_words", 32'(pop_idx), 32'd3000);
        check("rand_order_errors", 32'(mism), 32'd0);

        // Asynchronous reset while a read is in flight
        do_reset();
        @(negedge clk);
        drive(1'b1, 16'h7777, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        #1 check("mid_inflight_count", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_values("mid");
        @(negedge clk);
        rst_n = 1'b1;
        accepted = 0;
        for (int c = 0; c < 10 && accepted == 0; c++) begin
            @(negedge clk);
            drive(1'b1, 16'h1234, 1'b1);
            #1;
            if (bus.out_push_ready) accepted = 1;
        end
        check("mid_push_accepted", 32'(accepted), 32'd1);
        popped = 0;
        for (int c = 0; c < 20 && popped == 0; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 1'b1);
            #1;
            if (bus.out_pop_valid) begin
                check("mid_first_pop", 32'(bus.out_pop_data), 32'h1234);
                popped = 1;
            end
        end
        check("mid_pop_seen", 32'(popped), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
